// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing helpers for the multiplier datapath
//
// Purpose: FSM state encoding for the partial-product generator plus the
// width helpers used by every multiplier stage, so row and counter widths
// are derived in one place.
// Ports: none (package).

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } pp_state_e;

    // Default datapath configuration.
    localparam int XLEN_DEF = 32;
    localparam int RPC_DEF  = 4;
    localparam int ROW_W    = 2 * XLEN_DEF + 1;

    // One extra bit above the full product keeps the negated last row of a
    // signed multiply representable.
    function automatic int row_width(input int xlen);
        return 2 * xlen + 1;
    endfunction

    // Width of the GEN step counter; never narrower than one bit so a
    // single-step configuration still has a legal vector.
    function automatic int cnt_width(input int xlen, input int rpc);
        return ((xlen / rpc) > 1) ? $clog2(xlen / rpc) : 1;
    endfunction

endpackage

// File: rtl/pp_row.sv
// rtl/pp_row.sv - combinational generator for a single partial-product row
//
// Purpose: produce row k of the partial-product array from the extended
// multiplicand and multiplier bit k.
// Ports:
//   a_i      extended multiplicand (ROW_W bits)
//   b_i      multiplier bit selecting this row
//   k_i      row index, i.e. left-shift amount
//   signed_i operands are two's complement
//   last_i   this is the most significant row (k == XLEN-1)
//   row_o    generated row (ROW_W bits)

module pp_row
    import mult_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ROW_W = row_width(XLEN),
    parameter int KW    = $clog2(XLEN)
) (
    input  logic [ROW_W-1:0] a_i,
    input  logic             b_i,
    input  logic [KW-1:0]    k_i,
    input  logic             signed_i,
    input  logic             last_i,
    output logic [ROW_W-1:0] row_o
);

    logic [ROW_W-1:0] shifted;

    always_comb begin
        shifted = a_i << k_i;
        row_o   = '0;
        if (b_i) begin
            // The MSB of a two's complement multiplier carries weight
            // -2^(XLEN-1), so its row enters the sum negated.
            if (signed_i && last_i) begin
                row_o = ~shifted + ROW_W'(1);
            end else begin
                row_o = shifted;
            end
        end
    end

endmodule

// File: rtl/pp_gen.sv
// rtl/pp_gen.sv - partial-product generator at the head of the multiplier
//
// Purpose: accept one operand pair, build XLEN partial-product rows over
// XLEN/RowsPerCycle GEN cycles, then hold the full row vector for the
// reduction tree behind a valid/ready handshake.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   en_i               global enable; low freezes all state
//   flush_i            synchronous abort, overrides en_i
//   valid_i, ready_o   operand handshake
//   signed_i           operands are two's complement
//   op_a_i, op_b_i     multiplicand, multiplier
//   pp_o               partial-product rows, 2*XLEN+1 bits each
//   valid_o, ready_i   row-vector handshake

module pp_gen
    import mult_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NrRows       = 32,
    parameter int RowsPerCycle = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              signed_i,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    output logic [2*XLEN:0]   pp_o [NrRows],
    output logic              valid_o,
    input  logic              ready_i
);

    localparam int ROW_W    = row_width(XLEN);
    localparam int NR_STEPS = XLEN / RowsPerCycle;
    localparam int CW       = cnt_width(XLEN, RowsPerCycle);
    localparam int KW       = $clog2(XLEN);

    if (NrRows != XLEN) begin : g_bad_rows
        $error("pp_gen: NrRows must equal XLEN");
    end
    if ((XLEN % RowsPerCycle) != 0) begin : g_bad_rpc
        $error("pp_gen: RowsPerCycle must divide XLEN");
    end

    pp_state_e          state_q;
    logic [CW-1:0]      cnt_q;
    logic [XLEN-1:0]    a_q;
    logic [XLEN-1:0]    b_q;
    logic               sgn_q;
    logic [ROW_W-1:0]   pp_q [NrRows];

    logic [ROW_W-1:0]   a_ext;
    logic [KW-1:0]      row_idx [RowsPerCycle];
    logic [ROW_W-1:0]   row_gen [RowsPerCycle];

    assign a_ext = sgn_q ? {{(XLEN+1){a_q[XLEN-1]}}, a_q}
                         : {{(XLEN+1){1'b0}}, a_q};

    // Each GEN step covers a contiguous group of RowsPerCycle rows starting
    // at cnt_q*RowsPerCycle.
    for (genvar j = 0; j < RowsPerCycle; j++) begin : g_row
        assign row_idx[j] = KW'(int'(cnt_q) * RowsPerCycle + j);

        pp_row #(
            .XLEN  (XLEN),
            .ROW_W (ROW_W),
            .KW    (KW)
        ) u_pp_row (
            .a_i      (a_ext),
            .b_i      (b_q[row_idx[j]]),
            .k_i      (row_idx[j]),
            .signed_i (sgn_q),
            .last_i   (row_idx[j] == KW'(XLEN - 1)),
            .row_o    (row_gen[j])
        );
    end

    // Reset is folded into ready_o so the block never advertises space
    // while it is held in reset.
    assign ready_o = (state_q == IDLE) && en_i && rst_ni;
    assign valid_o = (state_q == DONE) && en_i;
    assign pp_o    = pp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            for (int i = 0; i < NrRows; i++) begin
                pp_q[i] <= '0;
            end
        end else if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NrRows; i++) begin
                pp_q[i] <= '0;
            end
        end else if (en_i) begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= op_a_i;
                        b_q     <= op_b_i;
                        sgn_q   <= signed_i;
                        cnt_q   <= '0;
                        state_q <= GEN;
                        for (int i = 0; i < NrRows; i++) begin
                            pp_q[i] <= '0;
                        end
                    end
                end
                GEN: begin
                    for (int j = 0; j < RowsPerCycle; j++) begin
                        pp_q[row_idx[j]] <= row_gen[j];
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NR_STEPS - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_gen.sv
// tb/tb_pp_gen.sv - self-checking bench for pp_gen against an arithmetic reference

module tb_pp_gen;

    localparam int XLEN = 8;
    localparam int R    = 2;
    localparam int N    = XLEN / R;
    localparam int RW   = 2 * XLEN + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic          valid_i;
    logic          ready_o;
    logic          sgn;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [RW-1:0] pp [XLEN];
    logic          valid_o;
    logic          ready_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pp_gen #(
        .XLEN         (XLEN),
        .NrRows       (XLEN),
        .RowsPerCycle (R)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .flush_i  (flush),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .signed_i (sgn),
        .op_a_i   (a),
        .op_b_i   (b),
        .pp_o     (pp),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Row k from the arithmetic definition: A * 2^k, negated for the
    // signed MSB row, taken mod 2^RW.
    function automatic logic [RW-1:0] ref_row(input logic [7:0] ra, input logic [7:0] rb,
                                              input logic rs, input int k);
        longint av;
        longint v;
        av = rs ? longint'($signed(ra)) : longint'(ra);
        if (!rb[k]) return '0;
        v = av * (longint'(1) << k);
        if (rs && k == XLEN - 1) v = -v;
        return v[RW-1:0];
    endfunction

    function automatic logic [RW-1:0] ref_prod(input logic [7:0] ra, input logic [7:0] rb,
                                               input logic rs);
        longint p;
        p = rs ? longint'($signed(ra)) * longint'($signed(rb)) : longint'(ra) * longint'(rb);
        return p[RW-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] ra, input logic [7:0] rb, input logic rs);
        int g = 0;
        a = ra; b = rb; sgn = rs; valid_i = 1'b1;
        while (!ready_o && g < 50) begin
            step();
            g++;
        end
        check("accept_ready", ready_o, 1);
        step();
        valid_i = 1'b0;
    endtask

    // Latency in cycles t0+lat where valid_o is first seen; optional en_i stall.
    task automatic wait_valid(input int st_at, input int st_len, output int lat);
        int n = 0;
        while (!valid_o && n < 40) begin
            if (st_len > 0 && n == st_at) en = 1'b0;
            if (st_len > 0 && n == st_at + st_len) en = 1'b1;
            step();
            n++;
        end
        en  = 1'b1;
        lat = n + 1;
    endtask

    task automatic check_rows(input string tag, input logic [7:0] ra, input logic [7:0] rb,
                              input logic rs);
        logic [RW-1:0] s = '0;
        for (int k = 0; k < XLEN; k++) begin
            check($sformatf("%s_row%0d", tag, k), pp[k], ref_row(ra, rb, rs, k));
            s += pp[k];
        end
        check({tag, "_sum"}, s, ref_prod(ra, rb, rs));
    endtask

    task automatic check_zero_rows(input string tag);
        for (int k = 0; k < XLEN; k++) begin
            check($sformatf("%s_row%0d", tag, k), pp[k], 0);
        end
    endtask

    task automatic release_out(input string tag);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check({tag, "_ready_after"}, ready_o, 1);
        check({tag, "_valid_after"}, valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        logic [7:0] ra, rb;
        logic rs;
        int st_at, st_len, hold;

        rst_n = 1'b1; en = 1'b1; flush = 1'b0; valid_i = 1'b0;
        sgn = 1'b0; a = '0; b = '0; ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_ready_held", ready_o, 0);
        check_zero_rows("rst");
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_ready_release", ready_o, 1);

        // Unsigned 3 * 5
        accept(8'd3, 8'd5, 1'b0);
        wait_valid(0, 0, lat);
        check("u_latency", lat, N + 1);
        check("u_row0", pp[0], 3);
        check("u_row2", pp[2], 12);
        check_rows("u", 8'd3, 8'd5, 1'b0);
        release_out("u");

        // Signed -3 * -2
        accept(8'hFD, 8'hFE, 1'b1);
        wait_valid(0, 0, lat);
        check("s_latency", lat, N + 1);
        check_rows("s", 8'hFD, 8'hFE, 1'b1);
        release_out("s");

        // Backpressure in DONE with an ignored valid_i pulse
        accept(8'h07, 8'h9A, 1'b0);
        wait_valid(0, 0, lat);
        check("bp_latency", lat, N + 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 8'hC5; b = 8'hFF; sgn = 1'b1; valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            step();
            check("bp_valid", valid_o, 1);
            check("bp_ready", ready_o, 0);
        end
        check_rows("bp", 8'h07, 8'h9A, 1'b0);
        release_out("bp");

        // Flush during the second GEN cycle
        accept(8'h55, 8'hFF, 1'b1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_ready", ready_o, 1);
        check_zero_rows("fl");
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid_o) bad++;
            step();
        end
        check("fl_no_valid", bad, 0);

        // en_i low for 3 cycles during GEN
        accept(8'hFD, 8'hFE, 1'b1);
        wait_valid(1, 3, lat);
        check("st_latency", lat, N + 4);
        check_rows("st", 8'hFD, 8'hFE, 1'b1);
        release_out("st");

        // Asynchronous reset while in DONE
        accept(8'h81, 8'hC3, 1'b1);
        wait_valid(0, 0, lat);
        check("ar_valid_before", valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", valid_o, 0);
        check("ar_ready_held", ready_o, 0);
        check_zero_rows("ar");
        step();
        rst_n = 1'b1;
        #1;
        check("ar_ready_release", ready_o, 1);

        // Randomised transactions with random stalls and backpressure
        for (int t = 0; t < 24; t++) begin
            ra     = 8'($urandom);
            rb     = 8'($urandom);
            rs     = 1'($urandom);
            st_len = $urandom_range(0, 2);
            st_at  = $urandom_range(0, N - 1);
            hold   = $urandom_range(0, 3);
            accept(ra, rb, rs);
            wait_valid(st_at, st_len, lat);
            check("rnd_latency", lat, N + 1 + st_len);
            for (int h = 0; h < hold; h++) step();
            check_rows("rnd", ra, rb, rs);
            release_out("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
